// File: rtl/mtsp_mem_arbiter.sv
// Round-robin arbiter that shares one memory-operation datapath among NUM_REQ
// command sources and sequences cache-LUT clears between operations.
module mtsp_mem_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int SIZE_W  = 12,
   parameter int ID_W    = 3
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   output logic [NUM_REQ-1:0]        REQ_READY,
   input  logic [NUM_REQ-1:0]        REQ_WRITE,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [NUM_REQ*SIZE_W-1:0] REQ_SIZE,
   output logic                      DESC_VALID,
   input  logic                      DESC_READY,
   output logic                      DESC_WRITE,
   output logic [ADDR_W-1:0]         DESC_ADDR,
   output logic [SIZE_W-1:0]         DESC_SIZE,
   output logic [ID_W-1:0]           DESC_ID,
   input  logic                      MEM_BUSY,
   input  logic                      CLEAR_REQ,
   output logic                      CLEAR_ACK,
   output logic                      CACHE_LUT_CLEAR,
   output logic                      BUSY
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_CLEAR
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic                 desc_valid_q, desc_valid_d;
   logic                 desc_write_q, desc_write_d;
   logic [ADDR_W-1:0]    desc_addr_q, desc_addr_d;
   logic [SIZE_W-1:0]    desc_size_q, desc_size_d;
   logic [ID_W-1:0]      desc_id_q, desc_id_d;
   logic                 clear_q, clear_d;

   logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
   logic [SIZE_W-1:0]    size_arr [NUM_REQ];
   logic                 grant_found;
   logic [IDX_W-1:0]     grant_idx;
   logic [IDX_W-1:0]     cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = REQ_ADDR[gi*ADDR_W +: ADDR_W];
         assign size_arr[gi] = REQ_SIZE[gi*SIZE_W +: SIZE_W];
      end
   endgenerate

   // Scan downward in offset so the candidate closest to the pointer wins last.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (REQ_VALID[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         req_ready_q  <= '0;
         desc_valid_q <= 1'b0;
         desc_write_q <= 1'b0;
         desc_addr_q  <= '0;
         desc_size_q  <= '0;
         desc_id_q    <= '0;
         clear_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         req_ready_q  <= req_ready_d;
         desc_valid_q <= desc_valid_d;
         desc_write_q <= desc_write_d;
         desc_addr_q  <= desc_addr_d;
         desc_size_q  <= desc_size_d;
         desc_id_q    <= desc_id_d;
         clear_q      <= clear_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      req_ready_d  = '0;
      desc_valid_d = desc_valid_q;
      desc_write_d = desc_write_q;
      desc_addr_d  = desc_addr_q;
      desc_size_d  = desc_size_q;
      desc_id_d    = desc_id_q;
      clear_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // CLEAR_REQ is still high in the acknowledge cycle; ignore it there.
            if (CLEAR_REQ && !clear_q) begin
               state_d = S_CLEAR;
            end else if (grant_found) begin
               state_d                = S_ISSUE;
               req_ready_d[grant_idx] = 1'b1;
               desc_valid_d           = 1'b1;
               desc_write_d           = REQ_WRITE[grant_idx];
               desc_addr_d            = addr_arr[grant_idx];
               desc_size_d            = size_arr[grant_idx];
               desc_id_d              = ID_W'(grant_idx);
               ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
         end
         S_ISSUE: begin
            if (DESC_READY) begin
               desc_valid_d = 1'b0;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: state_d = S_WAIT;
         S_WAIT: begin
            if (!MEM_BUSY) state_d = S_IDLE;
         end
         S_CLEAR: begin
            if (!MEM_BUSY) begin
               clear_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign REQ_READY       = req_ready_q;
   assign DESC_VALID      = desc_valid_q;
   assign DESC_WRITE      = desc_write_q;
   assign DESC_ADDR       = desc_addr_q;
   assign DESC_SIZE       = desc_size_q;
   assign DESC_ID         = desc_id_q;
   assign CLEAR_ACK       = clear_q;
   assign CACHE_LUT_CLEAR = clear_q;
   assign BUSY            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mtsp_mem_arbiter.sv
// Scoreboard-driven bench for mtsp_mem_arbiter: grants, fairness, stalls,
// clear sequencing and mid-operation reset.
module tb_mtsp_mem_arbiter;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;
   localparam int SIZE_W  = 12;
   localparam int ID_W    = 3;

   logic                      clk = 1'b0;
   logic                      nrst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*SIZE_W-1:0] req_size;
   logic                      desc_valid, desc_ready, desc_write;
   logic [ADDR_W-1:0]         desc_addr;
   logic [SIZE_W-1:0]         desc_size;
   logic [ID_W-1:0]           desc_id;
   logic                      mem_busy, clear_req, clear_ack, lut_clear, busy;

   typedef struct packed {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [SIZE_W-1:0] s;
      logic [ID_W-1:0]   id;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mtsp_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .ID_W(ID_W)) dut (
      .CLK(clk), .nRST(nrst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
      .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
      .DESC_VALID(desc_valid), .DESC_READY(desc_ready), .DESC_WRITE(desc_write),
      .DESC_ADDR(desc_addr), .DESC_SIZE(desc_size), .DESC_ID(desc_id),
      .MEM_BUSY(mem_busy), .CLEAR_REQ(clear_req), .CLEAR_ACK(clear_ack),
      .CACHE_LUT_CLEAR(lut_clear), .BUSY(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [SIZE_W-1:0] s);
      req_write[i] = w;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_size[i*SIZE_W +: SIZE_W] = s;
   endtask

   task automatic expect_grant(input logic w, input logic [ADDR_W-1:0] a, input logic [SIZE_W-1:0] s, input logic [ID_W-1:0] id);
      exp_t e;
      e.w = w; e.a = a; e.s = s; e.id = id;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      nrst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_size = '0;
      desc_ready = 1'b0; mem_busy = 1'b0; clear_req = 1'b0;
      step(); step();
      nrst = 1'b1;
      sb_q.delete();
   endtask

   task automatic drain();
      int k;
      req_valid = '0; clear_req = 1'b0; mem_busy = 1'b0; desc_ready = 1'b1;
      for (k = 0; k < 20; k++) begin
         step();
         if (busy === 1'b0) break;
      end
      n_cmp++; if (k == 20) begin n_err++; $display("FAIL drain_timeout busy=%b want 0", busy); end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
      n_cmp++; if ({desc_valid, desc_write, desc_addr, desc_size, desc_id} !== '0) begin n_err++; $display("FAIL reset_desc got %b %b %h %h %h want zeros", desc_valid, desc_write, desc_addr, desc_size, desc_id); end
      n_cmp++; if ({clear_ack, lut_clear, busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {clear_ack, lut_clear, busy}); end
   endtask

   task automatic test_single();
      exp_t e;
      do_reset();
      set_req(0, 1'b1, 32'h1000, 12'd4);
      req_valid = 2'b01; desc_ready = 1'b1;
      expect_grant(1'b1, 32'h1000, 12'd4, 3'd0);
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", req_ready); end
      n_cmp++; if (desc_valid !== 1'b1) begin n_err++; $display("FAIL single_desc_valid got %b want 1", desc_valid); end
      n_cmp++; if ({desc_write, desc_addr, desc_size, desc_id} !== e) begin n_err++; $display("FAIL single_desc got %h want %h", {desc_write, desc_addr, desc_size, desc_id}, e); end
      req_valid = 2'b00;
      step();
      n_cmp++; if ({desc_valid, req_ready, busy} !== 4'b0001) begin n_err++; $display("FAIL single_settle got %b want 0001", {desc_valid, req_ready, busy}); end
      mem_busy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_wait_busy cycle %0d got %b want 1", c, busy); end
      end
      mem_busy = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   exp_ptr, cyc, k;
      logic [NUM_REQ-1:0] oh;
      do_reset();
      set_req(0, 1'b0, 32'h2000, 12'd8);
      set_req(1, 1'b1, 32'h2100, 12'd9);
      desc_ready = 1'b1; mem_busy = 1'b0; req_valid = 2'b11;
      exp_ptr = 0;
      for (int g = 0; g < 6; g++) begin
         expect_grant(exp_ptr == 1, (exp_ptr == 1) ? 32'h2100 : 32'h2000, (exp_ptr == 1) ? 12'd9 : 12'd8, ID_W'(exp_ptr));
         exp_ptr = (exp_ptr + 1) % NUM_REQ;
      end
      cyc = 0;
      for (int g = 0; g < 6; g++) begin
         for (k = 0; k < 10; k++) begin
            step(); cyc++;
            if (req_ready !== 2'b00) break;
         end
         n_cmp++; if (k == 10) begin n_err++; $display("FAIL rr_timeout grant %0d got none want a grant", g); end
         e = sb_q.pop_front();
         oh = '0; oh[e.id[0]] = 1'b1;
         $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
         n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_ready grant %0d got %b want %b", g, req_ready, oh); end
         n_cmp++; if ({desc_write, desc_addr, desc_size, desc_id} !== e) begin n_err++; $display("FAIL rr_desc grant %0d got %h want %h", g, {desc_write, desc_addr, desc_size, desc_id}, e); end
         if (g > 0) begin
            n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL rr_spacing grant %0d got %0d want 4", g, cyc); end
         end
         cyc = 0;
      end
      drain();
   endtask

   task automatic test_stall();
      exp_t e;
      do_reset();
      set_req(0, 1'b0, 32'h3000, 12'd0);
      set_req(1, 1'b1, 32'h3100, 12'd5);
      expect_grant(1'b0, 32'h3000, 12'd0, 3'd0);
      expect_grant(1'b1, 32'h3100, 12'd5, 3'd1);
      req_valid = 2'b01; desc_ready = 1'b0;
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL stall_ready got %b want 01", req_ready); end
      req_valid = 2'b10;
      for (int c = 0; c < 10; c++) begin
         n_cmp++; if ({desc_valid, desc_write, desc_addr, desc_size, desc_id} !== {1'b1, e}) begin n_err++; $display("FAIL stall_hold cycle %0d got %h want %h", c, {desc_valid, desc_write, desc_addr, desc_size, desc_id}, {1'b1, e}); end
         if (c > 0) begin
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL stall_no_grant cycle %0d got %b want 00", c, req_ready); end
         end
         if (c < 9) step();
      end
      desc_ready = 1'b1;
      step();
      n_cmp++; if ({desc_valid, req_ready, busy} !== 4'b0001) begin n_err++; $display("FAIL stall_accept got %b want 0001", {desc_valid, req_ready, busy}); end
      step();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_wait got %b want 1", busy); end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_idle got %b want 0", busy); end
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL stall_next_ready got %b want 10", req_ready); end
      n_cmp++; if ({desc_write, desc_addr, desc_size, desc_id} !== e) begin n_err++; $display("FAIL stall_next_desc got %h want %h", {desc_write, desc_addr, desc_size, desc_id}, e); end
      drain();
   endtask

   task automatic test_clear_in_wait();
      exp_t e;
      int   k;
      do_reset();
      set_req(0, 1'b1, 32'h4000, 12'd16);
      expect_grant(1'b1, 32'h4000, 12'd16, 3'd0);
      req_valid = 2'b01; desc_ready = 1'b1;
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if ({req_ready, desc_write, desc_addr, desc_size, desc_id} !== {2'b01, e}) begin n_err++; $display("FAIL cw_first got %h want %h", {req_ready, desc_write, desc_addr, desc_size, desc_id}, {2'b01, e}); end
      set_req(0, 1'b0, 32'h4100, 12'd32);
      expect_grant(1'b0, 32'h4100, 12'd32, 3'd0);
      step();
      mem_busy = 1'b1;
      step();
      clear_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++; if ({lut_clear, clear_ack, req_ready} !== 4'b0000) begin n_err++; $display("FAIL cw_hold cycle %0d got %b want 0000", c, {lut_clear, clear_ack, req_ready}); end
      end
      mem_busy = 1'b0;
      for (k = 0; k < 10; k++) begin
         step();
         if (lut_clear === 1'b1) break;
         n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL cw_early_grant got %b want 00", req_ready); end
      end
      n_cmp++; if (k !== 2) begin n_err++; $display("FAIL cw_clear_delay got %0d want 2", k); end
      n_cmp++; if ({clear_ack, desc_valid, mem_busy} !== 3'b100) begin n_err++; $display("FAIL cw_ack got %b want 100", {clear_ack, desc_valid, mem_busy}); end
      clear_req = 1'b0;
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if ({req_ready, desc_write, desc_addr, desc_size, desc_id} !== {2'b01, e}) begin n_err++; $display("FAIL cw_after got %h want %h", {req_ready, desc_write, desc_addr, desc_size, desc_id}, {2'b01, e}); end
      n_cmp++; if ({lut_clear, clear_ack} !== 2'b00) begin n_err++; $display("FAIL cw_pulse_width got %b want 00", {lut_clear, clear_ack}); end
      drain();
   endtask

   task automatic test_clear_and_req();
      exp_t e;
      do_reset();
      set_req(0, 1'b1, 32'h5000, 12'd1);
      set_req(1, 1'b0, 32'h5100, 12'd2);
      expect_grant(1'b1, 32'h5000, 12'd1, 3'd0);
      req_valid = 2'b11; clear_req = 1'b1; desc_ready = 1'b1;
      step();
      n_cmp++; if ({req_ready, busy, lut_clear} !== 4'b0010) begin n_err++; $display("FAIL cr_clear_first got %b want 0010", {req_ready, busy, lut_clear}); end
      step();
      n_cmp++; if ({lut_clear, clear_ack, req_ready} !== 4'b1100) begin n_err++; $display("FAIL cr_pulse got %b want 1100", {lut_clear, clear_ack, req_ready}); end
      clear_req = 1'b0;
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if ({req_ready, desc_write, desc_addr, desc_size, desc_id} !== {2'b01, e}) begin n_err++; $display("FAIL cr_grant got %h want %h", {req_ready, desc_write, desc_addr, desc_size, desc_id}, {2'b01, e}); end
      drain();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   k;
      do_reset();
      set_req(0, 1'b1, 32'h6000, 12'd3);
      req_valid = 2'b01; desc_ready = 1'b0;
      step();
      n_cmp++; if (desc_valid !== 1'b1) begin n_err++; $display("FAIL rm_issue got %b want 1", desc_valid); end
      nrst = 1'b0;
      step();
      n_cmp++; if ({req_ready, desc_valid, desc_write, desc_addr, desc_size, desc_id, clear_ack, lut_clear, busy} !== '0) begin n_err++; $display("FAIL rm_zero got %h want 0", {req_ready, desc_valid, desc_write, desc_addr, desc_size, desc_id, clear_ack, lut_clear, busy}); end
      nrst = 1'b1;
      set_req(1, 1'b0, 32'h6100, 12'd7);
      expect_grant(1'b0, 32'h6100, 12'd7, 3'd1);
      req_valid = 2'b10; desc_ready = 1'b1;
      step();
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if ({req_ready, desc_write, desc_addr, desc_size, desc_id} !== {2'b10, e}) begin n_err++; $display("FAIL rm_grant1 got %h want %h", {req_ready, desc_write, desc_addr, desc_size, desc_id}, {2'b10, e}); end
      expect_grant(1'b1, 32'h6000, 12'd3, 3'd0);
      req_valid = 2'b11;
      for (k = 0; k < 10; k++) begin
         step();
         if (req_ready !== 2'b00) break;
      end
      e = sb_q.pop_front();
      $display("grant id=%0d addr=%h size=%0d write=%0b", desc_id, desc_addr, desc_size, desc_write);
      n_cmp++; if ({req_ready, desc_write, desc_addr, desc_size, desc_id} !== {2'b01, e}) begin n_err++; $display("FAIL rm_wrap got %h want %h after %0d cycles", {req_ready, desc_write, desc_addr, desc_size, desc_id}, {2'b01, e}, k); end
      drain();
   endtask

   initial begin
      nrst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_size = '0;
      desc_ready = 1'b0; mem_busy = 1'b0; clear_req = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_clear_in_wait();
      test_clear_and_req();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
